// File: rtl/pc_alu_unit.sv
// pc_alu_unit
//   Program-counter register with next-PC selection (sequential, branch, jump)
//   plus a combinational ALU.
//
// Ports
//   clk        : single clock, all state updates on rising edge
//   reset      : synchronous active-low reset, forces pc to 0
//   pcsrc      : select branch target pc+imm over pc+4
//   jump       : select jump target, overrides pcsrc
//   jump_src   : jump base, 0 = pc (JAL), 1 = srca (JALR)
//   imm        : sign-extended immediate
//   srca       : ALU operand A / JALR base
//   srcb       : ALU operand B
//   alucontrol : ALU operation code
//   pc         : current program counter (registered)
//   pcplus4    : pc + 4
//   pcbranch   : pc + imm
//   aluout     : ALU result
//   zero       : high when aluout is 0
module pc_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcsrc,
  input  logic             jump,
  input  logic             jump_src,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pcplus4,
  output logic [WIDTH-1:0] pcbranch,
  output logic [WIDTH-1:0] aluout,
  output logic             zero
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  logic [WIDTH-1:0] jump_base;
  logic [WIDTH-1:0] jump_sum;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] pcnext;
  logic [4:0]       shamt;

  assign pcplus4  = pc + PC_STEP;
  assign pcbranch = pc + imm;

  assign jump_base   = jump_src ? srca : pc;
  assign jump_sum    = jump_base + imm;
  // JALR-style targets must be halfword aligned, so bit 0 is dropped.
  assign jump_target = {jump_sum[WIDTH-1:1], 1'b0};

  always_comb begin
    pcnext = pcplus4;
    if (jump) begin
      pcnext = jump_target;
    end else if (pcsrc) begin
      pcnext = pcbranch;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= '0;
    end else begin
      pc <= pcnext;
    end
  end

  // Only the low five bits of srcb form the shift amount.
  assign shamt = srcb[4:0];

  always_comb begin
    aluout = '0;
    unique case (alucontrol)
      4'b0000: aluout = srca + srcb;
      4'b0001: aluout = srca - srcb;
      4'b0010: aluout = srca << shamt;
      4'b0011: aluout = ($signed(srca) < $signed(srcb)) ? WIDTH'(1) : '0;
      4'b0100: aluout = (srca < srcb) ? WIDTH'(1) : '0;
      4'b0101: aluout = srca ^ srcb;
      4'b0110: aluout = srca >> shamt;
      4'b0111: aluout = WIDTH'($signed(srca) >>> shamt);
      4'b1000: aluout = srca | srcb;
      4'b1001: aluout = srca & srcb;
      default: aluout = '0;
    endcase
  end

  assign zero = (aluout == '0);

endmodule

// File: tb/tb_pc_alu_unit.sv
module tb_pc_alu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcsrc;
  logic        jump;
  logic        jump_src;
  logic [31:0] imm;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [3:0]  alucontrol;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic [31:0] pcbranch;
  logic [31:0] aluout;
  logic        zero;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc;
  bit          m_valid = 1'b0;

  localparam longint MOD = 64'sd4294967296;

  always #5 clk = ~clk;

  pc_alu_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .pcsrc      (pcsrc),
    .jump       (jump),
    .jump_src   (jump_src),
    .imm        (imm),
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .pc         (pc),
    .pcplus4    (pcplus4),
    .pcbranch   (pcbranch),
    .aluout     (aluout),
    .zero       (zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wrap(input longint v);
    longint r;
    r = v % MOD;
    if (r < 0) r = r + MOD;
    return r[31:0];
  endfunction

  // Arithmetic view of the ALU: shifts as multiply/divide by powers of two.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    longint ua, ub, sa, sb, d;
    int     sh;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    d  = 64'sd1 << sh;
    case (op)
      4'd0: return wrap(ua + ub);
      4'd1: return wrap(ua - ub);
      4'd2: return wrap(ua * d);
      4'd3: return (sa < sb) ? 32'd1 : 32'd0;
      4'd4: return (ua < ub) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return wrap(ua / d);
      4'd7: return (sa >= 0) ? wrap(sa / d) : wrap(-((-sa + d - 1) / d));
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic cycle(input bit rst_n, input bit pcs, input bit jmp, input bit jsrc,
                       input logic [31:0] im, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op);
    logic [31:0] nxt;
    logic [31:0] r;
    longint      base;
    @(negedge clk);
    reset = rst_n; pcsrc = pcs; jump = jmp; jump_src = jsrc;
    imm = im; srca = a; srcb = b; alucontrol = op;
    #1;
    r = ref_alu(a, b, op);
    chk("aluout", aluout, r);
    chk("zero", {31'd0, zero}, {31'd0, (r == 32'd0)});
    if (m_valid) begin
      chk("pcplus4", pcplus4, wrap(longint'(m_pc) + 4));
      chk("pcbranch", pcbranch, wrap(longint'(m_pc) + longint'(im)));
    end
    if (!rst_n) begin
      nxt = 32'd0;
    end else if (jmp) begin
      base = jsrc ? longint'(a) : longint'(m_pc);
      nxt  = wrap(base + longint'(im));
      nxt  = nxt - (nxt % 2);
    end else if (pcs) begin
      nxt = wrap(longint'(m_pc) + longint'(im));
    end else begin
      nxt = wrap(longint'(m_pc) + 4);
    end
    @(posedge clk);
    #1;
    if (m_valid || !rst_n) chk("pc", pc, nxt);
    m_pc    = nxt;
    m_valid = 1'b1;
  endtask

  initial begin
    reset = 1'b0; pcsrc = 1'b0; jump = 1'b0; jump_src = 1'b0;
    imm = '0; srca = '0; srcb = '0; alucontrol = '0;

    // Reset then sequential stepping: 0, 4, 8, 12.
    cycle(1'b0, 0, 0, 0, 32'h0000_0123, 32'd5, 32'd7, 4'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_pcplus4", pcplus4, 32'd4);
    chk("rst_pcbranch", pcbranch, 32'h0000_0123);
    cycle(1'b1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 4'd0);
    chk("seq4", pc, 32'd4);
    cycle(1'b1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 4'd0);
    chk("seq8", pc, 32'd8);
    cycle(1'b1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 4'd0);
    chk("seq12", pc, 32'd12);

    // Backward branch from 8 to 0.
    cycle(1'b0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 4'd0);
    cycle(1'b1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 4'd0);
    cycle(1'b1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 4'd0);
    chk("at8", pc, 32'd8);
    cycle(1'b1, 1, 0, 0, 32'hFFFF_FFF8, 32'd0, 32'd0, 4'd0);
    chk("branch_back", pc, 32'd0);

    // Wrap of pc+4 at the top of the address space.
    cycle(1'b1, 0, 1, 1, 32'd0, 32'hFFFF_FFFC, 32'd0, 4'd0);
    chk("at_top", pc, 32'hFFFF_FFFC);
    cycle(1'b1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 4'd0);
    chk("pc_wrap", pc, 32'd0);

    // JALR beats branch and clears bit 0; then JAL from pc 0x10.
    cycle(1'b1, 1, 1, 1, 32'd4, 32'h0000_1001, 32'd0, 4'd0);
    chk("jalr", pc, 32'h0000_1004);
    cycle(1'b1, 0, 1, 1, 32'd0, 32'h0000_0010, 32'd0, 4'd0);
    cycle(1'b1, 0, 1, 0, 32'h20, 32'hDEAD_BEEF, 32'd0, 4'd0);
    chk("jal", pc, 32'h0000_0030);

    // ALU corner cases.
    cycle(1'b1, 0, 0, 0, 32'd0, 32'hFFFF_FFFF, 32'd1, 4'd0);
    chk("add_wrap", aluout, 32'd0);
    chk("add_zero", {31'd0, zero}, 32'd1);
    cycle(1'b1, 0, 0, 0, 32'd0, 32'hFFFF_FFFF, 32'd1, 4'd1);
    chk("sub", aluout, 32'hFFFF_FFFE);
    cycle(1'b1, 0, 0, 0, 32'd0, 32'hFFFF_FFFF, 32'd1, 4'd3);
    chk("slt", aluout, 32'd1);
    cycle(1'b1, 0, 0, 0, 32'd0, 32'hFFFF_FFFF, 32'd1, 4'd4);
    chk("sltu", aluout, 32'd0);
    cycle(1'b1, 0, 0, 0, 32'd0, 32'h8000_0000, 32'd4, 4'd7);
    chk("sra", aluout, 32'hF800_0000);
    cycle(1'b1, 0, 0, 0, 32'd0, 32'h8000_0000, 32'd4, 4'd6);
    chk("srl", aluout, 32'h0800_0000);
    cycle(1'b1, 0, 0, 0, 32'd0, 32'd1, 32'h0000_0021, 4'd2);
    chk("sll_mask", aluout, 32'd2);
    cycle(1'b1, 0, 0, 0, 32'd0, 32'h1234_5678, 32'h0F0F_0F0F, 4'hF);
    chk("op_f", aluout, 32'd0);
    chk("op_f_zero", {31'd0, zero}, 32'd1);

    // Reset wins over a pending jump.
    cycle(1'b0, 1, 1, 1, 32'h40, 32'h0000_2000, 32'd0, 4'd0);
    chk("rst_vs_jump", pc, 32'd0);
    cycle(1'b1, 0, 0, 0, 32'd0, 32'd0, 32'd0, 4'd0);
    chk("resume", pc, 32'd4);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rb;
      rb = $urandom();
      if ($urandom_range(0, 3) == 0) rb = rb % 64;
      cycle(($urandom_range(0, 15) != 0), 1'($urandom()), 1'($urandom()), 1'($urandom()),
            $urandom(), $urandom(), rb, 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
